// File: rtl/branch_pkg.sv
// Shared definitions for the branch resolution logic: op encoding and width.
package branch_pkg;

  localparam int OP_W = 3;

  typedef logic [OP_W-1:0] br_op_t;

  localparam br_op_t BR_NONE = 3'd0;
  localparam br_op_t BR_EQ   = 3'd1;
  localparam br_op_t BR_NE   = 3'd2;
  localparam br_op_t BR_LEZ  = 3'd3;
  localparam br_op_t BR_GTZ  = 3'd4;
  localparam br_op_t BR_LTZ  = 3'd5;
  localparam br_op_t BR_GEZ  = 3'd6;

  // Encoding 7 is reserved and behaves like BR_NONE.
  function automatic logic is_branch_op(input br_op_t op);
    return (op >= BR_EQ) && (op <= BR_GEZ);
  endfunction

endpackage

// File: rtl/branch_cond.sv
// Combinational branch-condition evaluator. Signed modes only look at a.
module branch_cond
  import branch_pkg::*;
#(
  parameter int WIDTH = 32
) (
  input  logic [OP_W-1:0]  op,
  input  logic [WIDTH-1:0] a,
  input  logic [WIDTH-1:0] b,
  output logic             cond
);

  logic a_neg;
  logic a_zero;

  assign a_neg  = a[WIDTH-1];
  assign a_zero = (a == '0);

  // Select the relation for the requested mode; NONE and reserved give 0.
  always_comb begin
    cond = 1'b0;
    case (op)
      BR_EQ:   cond = (a == b);
      BR_NE:   cond = (a != b);
      BR_LEZ:  cond = a_neg | a_zero;
      BR_GTZ:  cond = ~a_neg & ~a_zero;
      BR_LTZ:  cond = a_neg;
      BR_GEZ:  cond = ~a_neg;
      default: cond = 1'b0;
    endcase
  end

endmodule

// File: rtl/branch_resolve_unit.sv
// ID/EX branch resolution: condition, target adder, output register with
// stall/flush, and saturating branch / taken-branch counters.
module branch_resolve_unit
  import branch_pkg::*;
#(
  parameter int WIDTH = 32,
  parameter int CNT_W = 16
) (
  input  logic             clk,
  input  logic             reset,
  input  logic             in_valid,
  input  logic             stall,
  input  logic             flush,
  input  logic [OP_W-1:0]  op,
  input  logic [WIDTH-1:0] a,
  input  logic [WIDTH-1:0] b,
  input  logic [31:0]      pc,
  input  logic [15:0]      imm16,
  output logic             out_valid,
  output logic             taken,
  output logic [31:0]      target,
  output logic [CNT_W-1:0] branch_cnt,
  output logic [CNT_W-1:0] taken_cnt
);

  localparam logic [CNT_W-1:0] CNT_MAX = '1;
  localparam logic [CNT_W-1:0] CNT_ONE = CNT_W'(1);

  logic        cond;
  logic        is_br;
  logic        br_taken;
  logic [31:0] target_next;

  branch_cond #(.WIDTH(WIDTH)) u_cond (
    .op   (op),
    .a    (a),
    .b    (b),
    .cond (cond)
  );

  assign is_br       = in_valid & is_branch_op(op);
  assign br_taken    = is_br & cond;
  // Word offset sign-extended and scaled; 32-bit wrap is intentional.
  assign target_next = pc + 32'd4 + {{14{imm16[15]}}, imm16, 2'b00};

  // Output register: reset, then flush (squash, keep target/counters), then stall hold.
  always_ff @(posedge clk) begin
    if (reset) begin
      out_valid  <= 1'b0;
      taken      <= 1'b0;
      target     <= '0;
      branch_cnt <= '0;
      taken_cnt  <= '0;
    end else if (flush) begin
      out_valid <= 1'b0;
      taken     <= 1'b0;
    end else if (!stall) begin
      out_valid <= is_br;
      taken     <= br_taken;
      target    <= target_next;
      if (is_br && (branch_cnt != CNT_MAX))
        branch_cnt <= branch_cnt + CNT_ONE;
      if (br_taken && (taken_cnt != CNT_MAX))
        taken_cnt <= taken_cnt + CNT_ONE;
    end
  end

endmodule

// File: tb/tb_branch_resolve_unit.sv
// Self-checking bench for branch_resolve_unit with an expected-result queue.
module tb_branch_resolve_unit;
  import branch_pkg::*;

  logic        clk = 1'b0;
  logic        reset, in_valid, stall, flush;
  logic [2:0]  op;
  logic [31:0] a, b, pc;
  logic [15:0] imm16;

  logic        out_valid, taken;
  logic [31:0] target;
  logic [15:0] branch_cnt, taken_cnt;

  logic        out_valid2, taken2;
  logic [31:0] target2;
  logic [1:0]  branch_cnt2, taken_cnt2;

  int total = 0;
  int bad   = 0;

  logic        m_ov, m_tk;
  logic [31:0] m_tgt;
  logic [15:0] m_bc, m_tc;
  logic [65:0] sb[$];
  logic [65:0] exp_v;

  always #5 clk = ~clk;

  branch_resolve_unit #(.WIDTH(32), .CNT_W(16)) dut (
    .clk(clk), .reset(reset), .in_valid(in_valid), .stall(stall), .flush(flush),
    .op(op), .a(a), .b(b), .pc(pc), .imm16(imm16),
    .out_valid(out_valid), .taken(taken), .target(target),
    .branch_cnt(branch_cnt), .taken_cnt(taken_cnt)
  );

  branch_resolve_unit #(.WIDTH(32), .CNT_W(2)) dut_sat (
    .clk(clk), .reset(reset), .in_valid(in_valid), .stall(stall), .flush(flush),
    .op(op), .a(a), .b(b), .pc(pc), .imm16(imm16),
    .out_valid(out_valid2), .taken(taken2), .target(target2),
    .branch_cnt(branch_cnt2), .taken_cnt(taken_cnt2)
  );

  function automatic logic [65:0] obs();
    return {out_valid, taken, target, branch_cnt, taken_cnt};
  endfunction

  // Drive one cycle; c is the expected condition supplied by the caller's table.
  task automatic cycle(input logic r, input logic f, input logic s, input logic v,
                       input logic [2:0] o, input logic [31:0] aa, input logic [31:0] bb,
                       input logic [31:0] p, input logic [15:0] im, input logic c);
    logic br;
    reset = r; flush = f; stall = s; in_valid = v; op = o;
    a = aa; b = bb; pc = p; imm16 = im;
    br = v && (o >= 3'd1) && (o <= 3'd6);
    if (r) begin
      m_ov = 1'b0; m_tk = 1'b0; m_tgt = '0; m_bc = '0; m_tc = '0;
    end else if (f) begin
      m_ov = 1'b0; m_tk = 1'b0;
    end else if (!s) begin
      m_ov  = br;
      m_tk  = br && c;
      m_tgt = p + 32'd4 + {{14{im[15]}}, im, 2'b00};
      if (br && m_bc != 16'hFFFF) m_bc = m_bc + 16'd1;
      if (br && c && m_tc != 16'hFFFF) m_tc = m_tc + 16'd1;
    end
    sb.push_back({m_ov, m_tk, m_tgt, m_bc, m_tc});
    @(posedge clk);
    #1;
  endtask

  task automatic test_reset();
    cycle(1, 0, 0, 0, BR_NONE, 0, 0, 0, 0, 0);
    exp_v = sb.pop_front();
    total++;
    if (obs() !== exp_v) begin
      bad++; $display("FAIL reset: got %h want %h", obs(), exp_v);
    end
    total++;
    if ({out_valid2, taken2, target2, branch_cnt2, taken_cnt2} !== 36'd0) begin
      bad++; $display("FAIL reset_sat: got %h want 0", {out_valid2, taken2, target2, branch_cnt2, taken_cnt2});
    end
  endtask

  task automatic test_basic();
    cycle(0, 0, 0, 1, BR_EQ, 32'h1234, 32'h1234, 32'h0000_3000, 16'h0004, 1);
    exp_v = sb.pop_front();
    total++;
    if (obs() !== exp_v) begin
      bad++; $display("FAIL basic: got %h want %h", obs(), exp_v);
    end
    total++;
    if (obs() !== {1'b1, 1'b1, 32'h0000_3014, 16'd1, 16'd1}) begin
      bad++; $display("FAIL basic_const: got %h want 3_0000_3014_0001_0001", obs());
    end
  endtask

  task automatic test_conditions();
    logic [31:0] vals[5];
    logic [4:0]  tbl[4];
    logic [2:0]  ops[4];
    vals = '{32'h8000_0000, 32'hFFFF_FFFF, 32'h0, 32'h1, 32'h7FFF_FFFF};
    tbl  = '{5'b11100, 5'b00011, 5'b11000, 5'b00111};
    ops  = '{BR_LEZ, BR_GTZ, BR_LTZ, BR_GEZ};
    for (int k = 0; k < 4; k++) begin
      for (int j = 0; j < 5; j++) begin
        cycle(0, 0, 0, 1, ops[k], vals[j], 32'h5555_5555, 32'h0000_1000 + j * 4, 16'h0010, tbl[k][4-j]);
        exp_v = sb.pop_front();
        total++;
        if (obs() !== exp_v) begin
          bad++; $display("FAIL cond op=%0d a=%h: got %h want %h", ops[k], vals[j], obs(), exp_v);
        end
      end
    end
    cycle(0, 0, 0, 1, BR_NE, 32'd1, 32'd2, 32'h2000, 16'h0001, 1);
    exp_v = sb.pop_front();
    total++;
    if (obs() !== exp_v) begin
      bad++; $display("FAIL ne_taken: got %h want %h", obs(), exp_v);
    end
    cycle(0, 0, 0, 1, BR_EQ, 32'd1, 32'd2, 32'h2000, 16'h0001, 0);
    exp_v = sb.pop_front();
    total++;
    if (obs() !== exp_v) begin
      bad++; $display("FAIL eq_not_taken: got %h want %h", obs(), exp_v);
    end
    cycle(0, 0, 0, 1, 3'd7, 32'd3, 32'd3, 32'h2100, 16'h0002, 0);
    exp_v = sb.pop_front();
    total++;
    if (obs() !== exp_v || out_valid !== 1'b0) begin
      bad++; $display("FAIL op7: got %h want %h", obs(), exp_v);
    end
    cycle(0, 0, 0, 0, BR_EQ, 32'd3, 32'd3, 32'h2200, 16'h0002, 1);
    exp_v = sb.pop_front();
    total++;
    if (obs() !== exp_v) begin
      bad++; $display("FAIL invalid: got %h want %h", obs(), exp_v);
    end
  endtask

  task automatic test_target();
    logic [31:0] pcs[3];
    logic [15:0] imms[3];
    logic [31:0] tgts[3];
    pcs  = '{32'h0000_0000, 32'hFFFF_FFFC, 32'h0000_1000};
    imms = '{16'hFFFF, 16'h0000, 16'h8000};
    tgts = '{32'h0000_0000, 32'h0000_0000, 32'hFFFE_1004};
    for (int i = 0; i < 3; i++) begin
      cycle(0, 0, 0, 1, BR_GEZ, 32'd0, 32'd0, pcs[i], imms[i], 1);
      exp_v = sb.pop_front();
      total++;
      if (obs() !== exp_v || target !== tgts[i]) begin
        bad++; $display("FAIL target[%0d]: got %h want %h (target %h)", i, obs(), exp_v, tgts[i]);
      end
    end
  endtask

  task automatic test_stall_flush();
    cycle(0, 0, 0, 1, BR_NE, 32'd5, 32'd6, 32'h0000_0100, 16'h0010, 1);
    exp_v = sb.pop_front();
    total++;
    if (obs() !== exp_v) begin
      bad++; $display("FAIL pre_stall: got %h want %h", obs(), exp_v);
    end
    for (int i = 0; i < 3; i++) begin
      cycle(0, 0, 1, 1, BR_EQ, i, i, 32'h0000_0200 + i * 4, 16'(i), 1);
      exp_v = sb.pop_front();
      total++;
      if (obs() !== exp_v || target !== 32'h0000_0144) begin
        bad++; $display("FAIL stall[%0d]: got %h want %h", i, obs(), exp_v);
      end
    end
    cycle(0, 1, 1, 1, BR_EQ, 32'd7, 32'd7, 32'h0000_0300, 16'h0001, 1);
    exp_v = sb.pop_front();
    total++;
    if (obs() !== exp_v || out_valid !== 1'b0) begin
      bad++; $display("FAIL flush_stall: got %h want %h", obs(), exp_v);
    end
    cycle(0, 1, 0, 1, BR_GEZ, 32'd1, 32'd0, 32'h0000_0400, 16'h0001, 1);
    exp_v = sb.pop_front();
    total++;
    if (obs() !== exp_v) begin
      bad++; $display("FAIL flush: got %h want %h", obs(), exp_v);
    end
    cycle(0, 0, 0, 1, BR_EQ, 32'd9, 32'd9, 32'h0000_0500, 16'h0003, 1);
    exp_v = sb.pop_front();
    total++;
    if (obs() !== exp_v) begin
      bad++; $display("FAIL post_flush: got %h want %h", obs(), exp_v);
    end
    cycle(0, 0, 1, 1, BR_EQ, 32'd9, 32'd9, 32'h0000_0600, 16'h0003, 1);
    exp_v = sb.pop_front();
    total++;
    if (obs() !== exp_v) begin
      bad++; $display("FAIL stall2: got %h want %h", obs(), exp_v);
    end
    cycle(1, 0, 1, 1, BR_EQ, 32'd9, 32'd9, 32'h0000_0700, 16'h0003, 1);
    exp_v = sb.pop_front();
    total++;
    if (obs() !== exp_v || obs() !== 66'd0) begin
      bad++; $display("FAIL reset_in_stall: got %h want %h", obs(), exp_v);
    end
  endtask

  task automatic test_back_to_back();
    logic [2:0]  ops[6];
    logic [31:0] as[6];
    logic        cs[6];
    ops = '{BR_EQ, BR_NE, BR_LTZ, BR_GTZ, BR_EQ, BR_LEZ};
    as  = '{32'd4, 32'd4, 32'hF000_0000, 32'd0, 32'd8, 32'd0};
    cs  = '{1'b1, 1'b0, 1'b1, 1'b0, 1'b0, 1'b1};
    for (int i = 0; i < 6; i++) begin
      cycle(0, 0, 0, 1, ops[i], as[i], 32'd4, 32'h0040_0000 + i * 4, 16'(16'hFFF0 + i), cs[i]);
      exp_v = sb.pop_front();
      total++;
      if (obs() !== exp_v) begin
        bad++; $display("FAIL b2b[%0d]: got %h want %h", i, obs(), exp_v);
      end
    end
    total++;
    if (branch_cnt !== 16'd6 || taken_cnt !== 16'd3) begin
      bad++; $display("FAIL b2b_counts: got %0d/%0d want 6/3", branch_cnt, taken_cnt);
    end
  endtask

  task automatic test_saturate();
    cycle(1, 0, 0, 0, BR_NONE, 0, 0, 0, 0, 0);
    exp_v = sb.pop_front();
    total++;
    if (obs() !== exp_v) begin
      bad++; $display("FAIL sat_reset: got %h want %h", obs(), exp_v);
    end
    for (int i = 0; i < 5; i++) begin
      cycle(0, 0, 0, 1, BR_EQ, 32'd42, 32'd42, 32'h0000_8000, 16'h0001, 1);
      exp_v = sb.pop_front();
      total++;
      if (obs() !== exp_v) begin
        bad++; $display("FAIL sat_main[%0d]: got %h want %h", i, obs(), exp_v);
      end
    end
    total++;
    if (branch_cnt2 !== 2'd3 || taken_cnt2 !== 2'd3 || taken2 !== 1'b1) begin
      bad++; $display("FAIL saturate: got bc=%0d tc=%0d tk=%0d want 3 3 1", branch_cnt2, taken_cnt2, taken2);
    end
  endtask

  initial begin
    #100000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  initial begin
    reset = 1'b1; in_valid = 1'b0; stall = 1'b0; flush = 1'b0;
    op = '0; a = '0; b = '0; pc = '0; imm16 = '0;
    m_ov = 1'b0; m_tk = 1'b0; m_tgt = '0; m_bc = '0; m_tc = '0;
    test_reset();
    test_basic();
    test_conditions();
    test_target();
    test_stall_flush();
    test_back_to_back();
    test_saturate();
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule

// File: doc/branch_resolve_unit.md
# branch_resolve_unit

Parametrised branch-condition and target-resolution stage for the pipelined MIPS core. It succeeds the single-purpose equality comparator. It evaluates all six conditional-branch relations on `WIDTH`-bit operands and computes the branch target. It registers the result in one pipeline stage with stall/flush control, and keeps saturating branch and taken-branch statistics. It sits at the ID/EX boundary and feeds PC-select and flush logic.

## Interface
- `WIDTH`, 32: operand width in bits, ≥ 2.
- `CNT_W`, 16: width of each statistics counter, ≥ 1.

- `clk`  in  1  rising-edge clock, sole clock.
- `reset`  in  1  synchronous, active-high.
- `in_valid`  in  1  instruction in the stage is valid.
- `stall`  in  1  hold the output register.
- `flush`  in  1  squash the stage; has priority over `stall`.
- `op`  in  3  branch mode (see Operation).
- `a`  in  WIDTH  rs operand, already forwarded.
- `b`  in  WIDTH  rt operand, already forwarded.
- `pc`  in  32  address of the branch instruction.
- `imm16`  in  16  branch offset field.
- `out_valid`  out  1  registered: a valid branch was resolved.
- `taken`  out  1  registered: branch condition true.
- `target`  out  32  registered: pc + 4 + (sext(imm16) << 2).
- `branch_cnt`  out  CNT_W  resolved valid branches, saturating.
- `taken_cnt`  out  CNT_W  resolved taken branches, saturating.

## Operation
- `op` encoding:
  - 0: NONE
  - 1: EQ (a == b)
  - 2: NE (a != b)
  - 3: LEZ (signed a ≤ 0)
  - 4: GTZ (signed a > 0)
  - 5: LTZ (signed a < 0)
  - 6: GEZ (signed a ≥ 0)
  - 7: reserved, treated as NONE.
- Modes 3–6 ignore `b`. Signedness uses `a[WIDTH-1]` two's complement.
- `is_br` = `in_valid` and `op` ∈ 1..6. `cond` is the combinational relation for `op`.
- Per rising edge, in priority order:
  1. `reset`:
     - all outputs and counters load 0.
  2. `flush`:
     - `out_valid` and `taken` load 0.
     - `target` and counters hold.
  3. `stall`:
     - all registers hold.
  4. Otherwise (capture):
     - `out_valid` ← `is_br`.
     - `taken` ← `is_br` & `cond`.
     - `target` ← computed target (updated every capture, meaningful only when `out_valid`).
     - `branch_cnt` += 1 if `is_br`.
     - `taken_cnt` += 1 if `is_br` & `cond`.
- Target arithmetic is 32-bit, modulo 2^32: sign-extend `imm16` to 32 bits, shift left 2, add `pc` + 4. Wrap-around is silent.
- Counters saturate at 2^CNT_W − 1 and never wrap. `taken_cnt` ≤ `branch_cnt` always holds.
- `flush` and `stall` asserted together act as flush. Reset asserted mid-stall clears everything.

## Timing
- Latency: inputs sampled at edge N appear on outputs after edge N; they are valid from N until the next capture/flush/reset.
- All outputs are driven directly from registers, with no combinational input-to-output path.
- Reset values: `out_valid`=0, `taken`=0, `target`=0, `branch_cnt`=0, `taken_cnt`=0.
- During `stall`, outputs are stable for any number of cycles, and counters do not double-count a held instruction.
- Flush squashes the instruction presented in the same cycle; that instruction is never counted.
- One branch can be resolved per cycle, back-to-back, without bubbles.

## Structure
- Shared package `branch_pkg`:
  - `op` encoding constants (`BR_NONE`, `BR_EQ`, `BR_NE`, `BR_LEZ`, `BR_GTZ`, `BR_LTZ`, `BR_GEZ`).
  - Width constant for `op` (3).
- Sub-module `branch_cond`: combinational, parametrised by `WIDTH`; inputs `op`, `a`, `b`; output `cond`. It is reused by any future early-resolve logic.
- The top holds the target adder, the output register, and two saturating counters.

## Test plan
- Reset, then capture with `in_valid`=1, `op`=EQ, a=b=0x1234, pc=0x00003000, imm16=0x0004 → next cycle `out_valid`=1, `taken`=1, `target`=0x00003014, `branch_cnt`=1, `taken_cnt`=1.
- Each signed mode with `a` ∈ {0x80000000, 0xFFFFFFFF, 0, 1, 0x7FFFFFFF} → `taken` matches the table: LEZ taken for the first three, GTZ for the last two, LTZ for the first two, GEZ for the last three; NE with a=1, b=2 taken; `op`=7 → `out_valid`=0 and counters unchanged.
- Negative offset and wrap: pc=0x00000000, imm16=0xFFFF → `target`=0x00000000; pc=0xFFFFFFFC, imm16=0x0000 → `target`=0x00000000.
- Stall held 3 cycles with inputs changing → outputs and counters frozen. Flush+stall together → `out_valid`=0, counters unchanged. Synchronous `reset` during stall → all zero next edge.
- `CNT_W`=2, five consecutive taken EQ branches → `branch_cnt`=`taken_cnt`=3 (saturated), not 1.
